// File: rtl/sa_target_meter.sv
// sa_target_meter
// Measures the period of sig_in in clk cycles, averages 2^AVG_LOG2 periods,
// clips the result to [Y_MIN, Y_MAX] and hands it to the successive
// approximation controller through a 2-cycle start pulse. It then waits for
// sar_done before measuring the next window.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   meas_en      level enable, low forces IDLE
//   sig_in       asynchronous signal under measurement
//   sar_done     done from the controller
//   start        start request, high for exactly 2 cycles per result
//   target[9:0]  clipped averaged period
//   busy         high in every state except IDLE
//   ovf          sticky, a period in the current window saturated at 1023
//   clipped      last result was clipped
//   sar_timeout  sticky, sar_done not seen within DONE_TMO cycles
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | outputs hold, counters parked
// ARM       | waiting for the reference edge, nothing recorded
// MEASURE   | each edge / saturation records one period
// ISSUE     | target registered, start high for 2 cycles
// WAIT_DONE | waiting for sar_done, bounded by DONE_TMO

module sa_target_meter #(
    parameter int AVG_LOG2 = 2,
    parameter int Y_MIN    = 550,
    parameter int Y_MAX    = 1000,
    parameter int DONE_TMO = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       meas_en,
    input  logic       sig_in,
    input  logic       sar_done,
    output logic       start,
    output logic [9:0] target,
    output logic       busy,
    output logic       ovf,
    output logic       clipped,
    output logic       sar_timeout
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ARM       = 3'd1;
    localparam logic [2:0] MEASURE   = 3'd2;
    localparam logic [2:0] ISSUE     = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    localparam logic [3:0] NPER = 4'(1 << AVG_LOG2);
    localparam int TW = $clog2(DONE_TMO + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(DONE_TMO - 1);

    logic          sync1_q, sync2_q, sync3_q;
    logic [2:0]    state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [12:0]   acc_q, acc_d;
    logic [3:0]    idx_q, idx_d;
    logic          iss_q, iss_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [9:0]    target_q, target_d;
    logic          clipped_q, clipped_d;
    logic          ovf_q, ovf_d;
    logic          tmo_flag_q, tmo_flag_d;

    logic          sig_edge;
    logic          sat;
    logic          rec;
    logic [12:0]   sum_w;
    logic [12:0]   res_w;
    logic [9:0]    clip_val;
    logic          clip_hit;

    assign sig_edge = sync2_q & ~sync3_q;
    assign sat      = (cnt_q == 10'd1023);
    assign rec      = (state_q == MEASURE) && (sig_edge || sat);
    assign sum_w    = acc_q + {3'b000, cnt_q};
    assign res_w    = sum_w >> AVG_LOG2;

    always_comb begin
        clip_val = res_w[9:0];
        clip_hit = 1'b0;
        if (res_w < 13'(Y_MIN)) begin
            clip_val = 10'(Y_MIN);
            clip_hit = 1'b1;
        end else if (res_w > 13'(Y_MAX)) begin
            clip_val = 10'(Y_MAX);
            clip_hit = 1'b1;
        end
    end

    // The period counter keeps running outside MEASURE so that the edge
    // reference survives ISSUE and WAIT_DONE; the first period of the next
    // window is therefore a full, true period.
    always_comb begin
        if (state_q == IDLE) begin
            cnt_d = 10'd0;
        end else if (sig_edge || sat) begin
            cnt_d = 10'd1;
        end else begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        iss_d      = iss_q;
        tmo_d      = tmo_q;
        target_d   = target_q;
        clipped_d  = clipped_q;
        ovf_d      = ovf_q;
        tmo_flag_d = tmo_flag_q;

        if (!meas_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ARM;
                    ovf_d      = 1'b0;
                    tmo_flag_d = 1'b0;
                    acc_d      = 13'd0;
                    idx_d      = 4'd0;
                end
                ARM: begin
                    if (sig_edge) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rec) begin
                        // An edge coinciding with saturation is a real edge.
                        if (!sig_edge) begin
                            ovf_d = 1'b1;
                        end
                        if (4'(idx_q + 4'd1) == NPER) begin
                            // Register the result on the last record so it is
                            // valid together with the first start cycle.
                            state_d   = ISSUE;
                            target_d  = clip_val;
                            clipped_d = clip_hit;
                            iss_d     = 1'b0;
                        end else begin
                            acc_d = sum_w;
                            idx_d = 4'(idx_q + 4'd1);
                        end
                    end
                end
                ISSUE: begin
                    if (iss_q) begin
                        state_d = WAIT_DONE;
                        tmo_d   = TMO_LOAD;
                    end else begin
                        iss_d = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (sar_done) begin
                        state_d = MEASURE;
                        acc_d   = 13'd0;
                        idx_d   = 4'd0;
                    end else if (tmo_q == '0) begin
                        state_d    = ARM;
                        tmo_flag_d = 1'b1;
                        acc_d      = 13'd0;
                        idx_d      = 4'd0;
                    end else begin
                        tmo_d = tmo_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 10'd0;
            acc_q      <= 13'd0;
            idx_q      <= 4'd0;
            iss_q      <= 1'b0;
            tmo_q      <= '0;
            target_q   <= 10'(Y_MAX);
            clipped_q  <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            sync1_q    <= sig_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            iss_q      <= iss_d;
            tmo_q      <= tmo_d;
            target_q   <= target_d;
            clipped_q  <= clipped_d;
            ovf_q      <= ovf_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign start       = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign target      = target_q;
    assign clipped     = clipped_q;
    assign ovf         = ovf_q;
    assign sar_timeout = tmo_flag_q;

endmodule

// File: tb/tb_sa_target_meter.sv
module tb_sa_target_meter;

    logic       clk;
    logic       rst_n;
    logic       meas_en;
    logic       sig_in;
    logic       sar_done;
    logic       start;
    logic [9:0] target;
    logic       busy;
    logic       ovf;
    logic       clipped;
    logic       sar_timeout;

    int vectors;
    int miscompares;

    // Stimulus generator control: per_q holds successive periods between
    // rising edges; a 0 entry means no further rising edge.
    int  per_q[$];
    bit  gen_on;
    bit  sar_auto;

    sa_target_meter #(
        .AVG_LOG2(2),
        .Y_MIN(550),
        .Y_MAX(1000),
        .DONE_TMO(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .meas_en(meas_en),
        .sig_in(sig_in),
        .sar_done(sar_done),
        .start(start),
        .target(target),
        .busy(busy),
        .ovf(ovf),
        .clipped(clipped),
        .sar_timeout(sar_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sig_in generator: rising edges exactly cur clocks apart, high 8 clocks.
    initial begin
        int  gcnt;
        int  cur;
        bit  first;
        sig_in = 1'b0;
        gcnt   = 0;
        cur    = 0;
        first  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_on) begin
                first  = 1'b1;
                gcnt   = 0;
                sig_in = 1'b0;
            end else begin
                if (first) begin
                    first = 1'b0;
                    gcnt  = 0;
                    cur   = 0;
                    if (per_q.size() > 0) cur = per_q.pop_front();
                end else begin
                    gcnt++;
                    if (cur > 0 && gcnt == cur) begin
                        gcnt = 0;
                        if (per_q.size() > 0) cur = per_q.pop_front();
                    end
                end
                sig_in = (gcnt < 8);
            end
        end
    end

    // Controller model: done rises 5 cycles after start falls, clears on start.
    initial begin
        bit prev_start;
        int dly;
        sar_done   = 1'b0;
        prev_start = 1'b0;
        dly        = -1;
        forever begin
            @(posedge clk);
            #1;
            if (start) begin
                sar_done = 1'b0;
                dly      = -1;
            end else if (prev_start) begin
                dly = 5;
            end else if (dly > 0) begin
                dly--;
            end
            if (!start && dly == 0 && sar_auto) sar_done = 1'b1;
            if (!sar_auto) sar_done = 1'b0;
            prev_start = start;
        end
    end

    task automatic session_start();
        meas_en = 1'b0;
        gen_on  = 1'b0;
        repeat (3) @(negedge clk);
        meas_en = 1'b1;
        repeat (2) @(negedge clk);
        gen_on = 1'b1;
    endtask

    task automatic wait_start(input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: start not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        meas_en = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (start !== 1'b0)      begin miscompares++; $display("FAIL reset_start: got %b want 0", start); end
        vectors++; if (target !== 10'd1000) begin miscompares++; $display("FAIL reset_target: got %0d want 1000", target); end
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (ovf !== 1'b0)        begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        vectors++; if (clipped !== 1'b0)    begin miscompares++; $display("FAIL reset_clipped: got %b want 0", clipped); end
        vectors++; if (sar_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", sar_timeout); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_constant();
        bit ok;
        sar_auto = 1'b1;
        per_q = '{630};
        session_start();
        for (int w = 0; w < 2; w++) begin
            wait_start(6000, "const_start", ok);
            if (ok) begin
                vectors++; if (target !== 10'd630) begin miscompares++; $display("FAIL const_target w%0d: got %0d want 630", w, target); end
                vectors++; if (clipped !== 1'b0)   begin miscompares++; $display("FAIL const_clipped w%0d: got %b want 0", w, clipped); end
                vectors++; if (busy !== 1'b1)      begin miscompares++; $display("FAIL const_busy w%0d: got %b want 1", w, busy); end
                @(negedge clk);
                vectors++; if (start !== 1'b1)     begin miscompares++; $display("FAIL const_start2 w%0d: got %b want 1", w, start); end
                @(negedge clk);
                vectors++; if (start !== 1'b0)     begin miscompares++; $display("FAIL const_start3 w%0d: got %b want 0", w, start); end
                vectors++; if (target !== 10'd630) begin miscompares++; $display("FAIL const_hold w%0d: got %0d want 630", w, target); end
            end
        end
    endtask

    task automatic test_truncation();
        bit ok;
        sar_auto = 1'b1;
        per_q = '{628, 632, 631, 630, 780};
        session_start();
        wait_start(6000, "trunc_start", ok);
        if (ok) begin
            vectors++; if (target !== 10'd630) begin miscompares++; $display("FAIL trunc_target: got %0d want 630", target); end
            vectors++; if (clipped !== 1'b0)   begin miscompares++; $display("FAIL trunc_clipped: got %b want 0", clipped); end
            repeat (2) @(negedge clk);
        end
        wait_start(6000, "step_start", ok);
        if (ok) begin
            vectors++; if (target !== 10'd780) begin miscompares++; $display("FAIL step_target: got %0d want 780", target); end
            vectors++; if (clipped !== 1'b0)   begin miscompares++; $display("FAIL step_clipped: got %b want 0", clipped); end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_clip();
        bit ok;
        sar_auto = 1'b1;
        per_q = '{400};
        session_start();
        wait_start(6000, "clip_lo_start", ok);
        if (ok) begin
            vectors++; if (target !== 10'd550) begin miscompares++; $display("FAIL clip_lo_target: got %0d want 550", target); end
            vectors++; if (clipped !== 1'b1)   begin miscompares++; $display("FAIL clip_lo_flag: got %b want 1", clipped); end
        end
        per_q = '{1010};
        session_start();
        wait_start(6500, "clip_hi_start", ok);
        if (ok) begin
            vectors++; if (target !== 10'd1000) begin miscompares++; $display("FAIL clip_hi_target: got %0d want 1000", target); end
            vectors++; if (clipped !== 1'b1)    begin miscompares++; $display("FAIL clip_hi_flag: got %b want 1", clipped); end
            vectors++; if (ovf !== 1'b0)        begin miscompares++; $display("FAIL clip_hi_ovf: got %b want 0", ovf); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        sar_auto = 1'b1;
        per_q = '{0};
        session_start();
        wait_start(6000, "ovf_start", ok);
        if (ok) begin
            vectors++; if (ovf !== 1'b1)        begin miscompares++; $display("FAIL ovf_flag: got %b want 1", ovf); end
            vectors++; if (target !== 10'd1000) begin miscompares++; $display("FAIL ovf_target: got %0d want 1000", target); end
            vectors++; if (clipped !== 1'b1)    begin miscompares++; $display("FAIL ovf_clipped: got %b want 1", clipped); end
        end
        meas_en = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_idle_busy: got %b want 0", busy); end
        vectors++; if (ovf !== 1'b1)  begin miscompares++; $display("FAIL ovf_idle_hold: got %b want 1", ovf); end
        meas_en = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovf_rearm_busy: got %b want 1", busy); end
        vectors++; if (ovf !== 1'b0)  begin miscompares++; $display("FAIL ovf_rearm_clear: got %b want 0", ovf); end
    endtask

    task automatic test_timeout();
        bit ok;
        sar_auto = 1'b0;
        per_q = '{630};
        session_start();
        wait_start(6000, "tmo_start", ok);
        if (ok) begin
            repeat (2) @(negedge clk);   // first WAIT_DONE cycle
            vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL tmo_wait_start: got %b want 0", start); end
            repeat (63) @(negedge clk);
            vectors++; if (sar_timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b want 0", sar_timeout); end
            @(negedge clk);
            vectors++; if (sar_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_flag: got %b want 1", sar_timeout); end
            vectors++; if (busy !== 1'b1)        begin miscompares++; $display("FAIL tmo_busy: got %b want 1", busy); end
            vectors++; if (start !== 1'b0)       begin miscompares++; $display("FAIL tmo_arm_start: got %b want 0", start); end
        end
        wait_start(6000, "tmo_rearm_start", ok);
        if (ok) begin
            vectors++; if (target !== 10'd630)   begin miscompares++; $display("FAIL tmo_rearm_target: got %0d want 630", target); end
            vectors++; if (sar_timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b want 1", sar_timeout); end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_in_issue();
        bit ok;
        wait_start(6000, "rst_issue_start", ok);
        if (ok) begin
            rst_n = 1'b0;
            @(negedge clk);
            vectors++; if (start !== 1'b0)       begin miscompares++; $display("FAIL rst_issue_start: got %b want 0", start); end
            vectors++; if (target !== 10'd1000)  begin miscompares++; $display("FAIL rst_issue_target: got %0d want 1000", target); end
            vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_issue_busy: got %b want 0", busy); end
            vectors++; if (sar_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_issue_timeout: got %b want 0", sar_timeout); end
            vectors++; if (ovf !== 1'b0)         begin miscompares++; $display("FAIL rst_issue_ovf: got %b want 0", ovf); end
            vectors++; if (clipped !== 1'b0)     begin miscompares++; $display("FAIL rst_issue_clipped: got %b want 0", clipped); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_meas_en_drop();
        bit ok;
        sar_auto = 1'b1;
        per_q = '{630};
        session_start();
        wait_start(6000, "drop_start", ok);
        if (ok) begin
            vectors++; if (target !== 10'd630) begin miscompares++; $display("FAIL drop_first_target: got %0d want 630", target); end
            repeat (200) @(negedge clk);
            meas_en = 1'b0;
            @(negedge clk);
            vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL drop_busy: got %b want 0", busy); end
            vectors++; if (start !== 1'b0)     begin miscompares++; $display("FAIL drop_start: got %b want 0", start); end
            vectors++; if (target !== 10'd630) begin miscompares++; $display("FAIL drop_target: got %0d want 630", target); end
            repeat (20) @(negedge clk);
            vectors++; if (target !== 10'd630) begin miscompares++; $display("FAIL drop_target_hold: got %0d want 630", target); end
            vectors++; if (clipped !== 1'b0)   begin miscompares++; $display("FAIL drop_clipped_hold: got %b want 0", clipped); end
        end
        gen_on = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        meas_en     = 1'b0;
        gen_on      = 1'b0;
        sar_auto    = 1'b0;
        test_reset();
        test_constant();
        test_truncation();
        test_clip();
        test_overflow();
        test_timeout();
        test_reset_in_issue();
        test_meas_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
